dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder serving the pipeline's load/store requests over a valid/ready request channel and a valid/ready response channel.
- Holds a word-addressed RAM and applies byte/half/word store lane steering.
- Returns load data right-justified, so downstream load extension works from bit 0.
- Inserts a programmable number of wait states and flags misaligned or out-of-range accesses instead of performing them.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the RAM; index range 0..DEPTH_WORDS-1.
- WAIT_CYCLES, 1, extra wait states between request accept and memory access; legal range 0..15.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-justified (byte in [7:0], half in [15:0]).
- resp_valid  output  1  response present.
- resp_ready  input  1  consumer accepts the response.
- resp_rdata  output  32  load data, right-justified and zero-filled above the access size; 0 for stores and for errors.
- resp_err  output  1  access rejected (misaligned, out of range, or illegal size).

Behaviour:
- Reset, asynchronous, while rst_n=0:
  - state=IDLE, wait counter=0.
  - resp_valid=0, resp_rdata=0, resp_err=0.
  - req_ready=0, because req_ready is gated by rst_n.
  - RAM contents are not reset.
- One outstanding transaction only.
- States:
  - IDLE:
    - req_ready=1.
    - On req_valid at a rising edge, latch we/size/addr/wdata.
    - Go to WAIT with counter=WAIT_CYCLES-1 if WAIT_CYCLES>0.
    - If WAIT_CYCLES=0, perform the access on that same edge and go to RESP.
  - WAIT:
    - req_ready=0; the counter decrements each cycle.
    - On the edge where the counter is 0, perform the access and go to RESP.
  - RESP:
    - resp_valid=1; resp_rdata and resp_err stay stable until handshake.
    - On resp_ready=1 at an edge, go to IDLE.
    - req_ready stays 0 in RESP, so there is no same-cycle turnaround.
- Latency: request accepted at edge T gives resp_valid=1 in the cycle after edge T+WAIT_CYCLES. The minimum request-to-request cadence is WAIT_CYCLES+2 cycles with resp_ready held high.
- Error check, done on the latched request:
  - size=01 with addr[0]=1 is an error.
  - size=10 with addr[1:0]!=00 is an error.
  - size=11 is an error.
  - addr[31:2] >= DEPTH_WORDS is an error.
  - On error: no RAM read or write, resp_err=1, resp_rdata=0.
- Store:
  - Byte: byte enable = 1<<addr[1:0]; wdata[7:0] is replicated to all lanes.
  - Half: enables 0011 or 1100 selected by addr[1]; wdata[15:0] is replicated.
  - Word: enables 1111.
  - Only enabled lanes change. resp_rdata=0, resp_err=0.
- Load:
  - Read word at addr[31:2], shift right by 8*addr[1:0].
  - Mask to 8 bits for byte, 16 bits for half, 32 bits for word.
- Reset mid-operation:
  - A store still in WAIT when rst_n falls is never committed.
  - A pending response is discarded; resp_valid drops immediately.
- Inputs are sampled only in IDLE; request inputs in WAIT/RESP are ignored.

Test Plan:
- Reset: WAIT_CYCLES=1, rst_n=0 -> req_ready=0, resp_valid=0. Release rst_n -> req_ready=1 next cycle.
- Word store then load: store addr 0x10, data 0xDEADBEEF; load 0x10 -> resp_rdata=0xDEADBEEF, resp_err=0. resp_valid rises 2 cycles after request accept.
- Byte/half lanes: word 0x11223344 at 0x20.
  - Store byte 0xAA at 0x21 -> word reads 0x1122AA44.
  - Load half at 0x22 -> 0x00001122.
  - Load byte at 0x23 -> 0x00000011.
- Errors: word load at 0x22, half store at 0x25, address 4*DEPTH_WORDS, size=11 -> resp_err=1 and resp_rdata=0 each time. A later load shows memory unchanged.
- Backpressure: hold resp_ready=0 for 5 cycles -> resp_valid, resp_rdata and resp_err stay stable, and req_ready=0 throughout. Release -> IDLE next cycle.
- Reset mid-store and zero-wait mode:
  - WAIT_CYCLES=4: assert rst_n=0 during WAIT of a store to 0x40 -> later load of 0x40 returns the old value.
  - WAIT_CYCLES=0: store then load -> response 1 cycle after accept.

Source files
------------

// File: rtl/dmem_responder_if.sv
// Request/response bus between the pipeline and the data-memory responder.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_size, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM with byte/half/word lane steering, programmable
// wait states, and error flagging for misaligned, out-of-range or illegal accesses.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input logic             clk,
    input logic             rst_n,
    dmem_responder_if.slave bus
);
    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_INIT = (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             lat_we;
    logic [1:0]       lat_size;
    logic [31:0]      lat_addr, lat_wdata;
    logic [31:0]      rdata_q;
    logic             err_q;
    logic [31:0]      mem [DEPTH_WORDS];

    logic             accept_c, access_c;
    logic             acc_we;
    logic [1:0]       acc_size;
    logic [31:0]      acc_addr, acc_wdata;
    logic             err_c;
    logic [IDX_W-1:0] idx_c;
    logic [3:0]       be_c;
    logic [31:0]      wlane_c, rword_c, rshift_c, rdata_c;

    assign bus.req_ready  = rst_n & (state == ST_IDLE);
    assign bus.resp_valid = (state == ST_RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;

    // Zero-wait accesses happen on the accept edge, so they use the live request.
    always_comb begin
        acc_we    = lat_we;
        acc_size  = lat_size;
        acc_addr  = lat_addr;
        acc_wdata = lat_wdata;
        if (state == ST_IDLE) begin
            acc_we    = bus.req_we;
            acc_size  = bus.req_size;
            acc_addr  = bus.req_addr;
            acc_wdata = bus.req_wdata;
        end
    end

    // Next-state logic; rst_n gates accept so the RAM cannot be written during reset.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept_c   = 1'b0;
        access_c   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.req_valid && rst_n) begin
                    accept_c = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        access_c   = 1'b1;
                        state_next = ST_RESP;
                    end else begin
                        cnt_next   = CNT_INIT;
                        state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt == '0) begin
                    access_c   = 1'b1;
                    state_next = ST_RESP;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (bus.resp_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Access decode: error check, lane enables, store replication, load alignment.
    always_comb begin
        err_c = (acc_size == 2'b11)
              | ((acc_size == 2'b01) & acc_addr[0])
              | ((acc_size == 2'b10) & (acc_addr[1:0] != 2'b00))
              | ({2'b00, acc_addr[31:2]} >= 32'(DEPTH_WORDS));
        idx_c = acc_addr[IDX_W+1:2];
        case (acc_size)
            2'b00: begin
                be_c    = 4'b0001 << acc_addr[1:0];
                wlane_c = {4{acc_wdata[7:0]}};
            end
            2'b01: begin
                be_c    = acc_addr[1] ? 4'b1100 : 4'b0011;
                wlane_c = {2{acc_wdata[15:0]}};
            end
            default: begin
                be_c    = 4'b1111;
                wlane_c = acc_wdata;
            end
        endcase
        rword_c  = mem[idx_c];
        rshift_c = rword_c >> {acc_addr[1:0], 3'b000};
        case (acc_size)
            2'b00:   rdata_c = {24'd0, rshift_c[7:0]};
            2'b01:   rdata_c = {16'd0, rshift_c[15:0]};
            default: rdata_c = rshift_c;
        endcase
    end

    // RAM write port; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (access_c && acc_we && !err_c) begin
            for (int i = 0; i < 4; i++) begin
                if (be_c[i]) mem[idx_c][8*i +: 8] <= wlane_c[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            lat_we    <= 1'b0;
            lat_size  <= 2'b00;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept_c) begin
                lat_we    <= bus.req_we;
                lat_size  <= bus.req_size;
                lat_addr  <= bus.req_addr;
                lat_wdata <= bus.req_wdata;
            end
            if (access_c) begin
                err_q   <= err_c;
                rdata_q <= (err_c || acc_we) ? '0 : rdata_c;
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (1, 0 and 4 wait states) against a byte-level memory model.
module tb_dmem_responder;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int          sel;
    logic        tb_valid, tb_we, tb_resp_ready;
    logic [1:0]  tb_size;
    logic [31:0] tb_addr, tb_wdata;
    logic        ob_ready, ob_valid, ob_err;
    logic [31:0] ob_rdata;
    int          tests_run, tests_failed;

    logic [31:0] model_mem [3][1024];

    dmem_responder_if bus_a ();
    dmem_responder_if bus_b ();
    dmem_responder_if bus_c ();

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
    dmem_responder #(.DEPTH_WORDS(64),   .WAIT_CYCLES(0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b.slave));
    dmem_responder #(.DEPTH_WORDS(64),   .WAIT_CYCLES(4)) dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c.slave));

    assign bus_a.req_valid = tb_valid && (sel == 0);
    assign bus_b.req_valid = tb_valid && (sel == 1);
    assign bus_c.req_valid = tb_valid && (sel == 2);
    assign bus_a.resp_ready = tb_resp_ready && (sel == 0);
    assign bus_b.resp_ready = tb_resp_ready && (sel == 1);
    assign bus_c.resp_ready = tb_resp_ready && (sel == 2);
    assign bus_a.req_we = tb_we;    assign bus_b.req_we = tb_we;    assign bus_c.req_we = tb_we;
    assign bus_a.req_size = tb_size; assign bus_b.req_size = tb_size; assign bus_c.req_size = tb_size;
    assign bus_a.req_addr = tb_addr; assign bus_b.req_addr = tb_addr; assign bus_c.req_addr = tb_addr;
    assign bus_a.req_wdata = tb_wdata; assign bus_b.req_wdata = tb_wdata; assign bus_c.req_wdata = tb_wdata;

    assign ob_ready = (sel == 0) ? bus_a.req_ready  : (sel == 1) ? bus_b.req_ready  : bus_c.req_ready;
    assign ob_valid = (sel == 0) ? bus_a.resp_valid : (sel == 1) ? bus_b.resp_valid : bus_c.resp_valid;
    assign ob_rdata = (sel == 0) ? bus_a.resp_rdata : (sel == 1) ? bus_b.resp_rdata : bus_c.resp_rdata;
    assign ob_err   = (sel == 0) ? bus_a.resp_err   : (sel == 1) ? bus_b.resp_err   : bus_c.resp_err;

    function automatic int wait_of(input int s);
        return (s == 0) ? 1 : (s == 1) ? 0 : 4;
    endfunction

    function automatic int unsigned depth_of(input int s);
        return (s == 0) ? 1024 : 64;
    endfunction

    // Reference: an access touches n consecutive bytes starting at addr.
    function automatic void model_access(input int s, input logic we, input logic [1:0] size,
                                         input logic [31:0] addr, input logic [31:0] wd,
                                         output logic [31:0] rd, output logic er);
        int unsigned n, off, widx;
        logic [31:0] word;
        n    = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        off  = addr % 4;
        widx = addr / 4;
        er   = (size == 2'd3) || ((addr % n) != 0) || (widx >= depth_of(s));
        rd   = '0;
        if (!er) begin
            word = model_mem[s][widx];
            if (we) begin
                for (int unsigned k = 0; k < n; k++) word[8*(off+k) +: 8] = wd[8*k +: 8];
                model_mem[s][widx] = word;
            end else begin
                rd = word >> (8 * off);
                if (n < 4) rd = rd & ((32'd1 << (8 * n)) - 32'd1);
            end
        end
    endfunction

    // Issues one request and waits for resp_valid; lat = edges after accept, -1 on timeout.
    task automatic txn(input logic we, input logic [1:0] size, input logic [31:0] addr,
                       input logic [31:0] wd, output logic [31:0] rd, output logic er, output int lat);
        int guard;
        @(negedge clk);
        tb_we = we; tb_size = size; tb_addr = addr; tb_wdata = wd; tb_valid = 1'b1;
        guard = 0;
        while (!ob_ready && guard < 20) begin @(negedge clk); guard++; end
        @(posedge clk); #1 tb_valid = 1'b0;
        lat = -1;
        for (int c = 0; c < 40 && lat < 0; c++) begin
            @(negedge clk);
            if (ob_valid) lat = c;
            else @(posedge clk);
        end
        rd = ob_rdata; er = ob_err;
    endtask

    task automatic release_resp;
        tb_resp_ready = 1'b1;
        @(posedge clk); #1 tb_resp_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s; #1;
            tests_run++; if (ob_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready dut%0d got=%b exp=0", s, ob_ready); end
            tests_run++; if (ob_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid dut%0d got=%b exp=0", s, ob_valid); end
        end
        sel = 0;
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++; if (ob_ready !== 1'b1) begin tests_failed++; $display("FAIL post_reset_ready got=%b exp=1", ob_ready); end
    endtask

    task automatic test_init;
        logic [31:0] rd, erd, wd; logic er, eer; int lat;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            for (int w = 0; w < 32; w++) begin
                wd = $urandom;
                model_access(s, 1'b1, 2'd2, 32'(4 * w), wd, erd, eer);
                txn(1'b1, 2'd2, 32'(4 * w), wd, rd, er, lat);
                tests_run++; if (er !== 1'b0 || lat != wait_of(s)) begin tests_failed++; $display("FAIL init_store dut%0d w%0d err=%b lat=%0d exp err=0 lat=%0d", s, w, er, lat, wait_of(s)); end
                release_resp();
            end
        end
    endtask

    task automatic test_word;
        logic [31:0] rd, erd; logic er, eer; int lat;
        sel = 0;
        model_access(0, 1'b1, 2'd2, 32'h10, 32'hDEADBEEF, erd, eer);
        txn(1'b1, 2'd2, 32'h10, 32'hDEADBEEF, rd, er, lat);
        tests_run++; if (rd !== 32'h0 || er !== 1'b0) begin tests_failed++; $display("FAIL word_store rdata=%h err=%b exp 0/0", rd, er); end
        tests_run++; if (lat != 1) begin tests_failed++; $display("FAIL word_store_latency got=%0d exp=1", lat); end
        release_resp();
        txn(1'b0, 2'd2, 32'h10, 32'h0, rd, er, lat);
        tests_run++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin tests_failed++; $display("FAIL word_load rdata=%h err=%b exp deadbeef/0", rd, er); end
        tests_run++; if (lat != 1) begin tests_failed++; $display("FAIL word_load_latency got=%0d exp=1", lat); end
        release_resp();
    endtask

    task automatic test_lanes;
        logic [31:0] rd, erd; logic er, eer; int lat;
        sel = 0;
        model_access(0, 1'b1, 2'd2, 32'h20, 32'h11223344, erd, eer);
        txn(1'b1, 2'd2, 32'h20, 32'h11223344, rd, er, lat); release_resp();
        model_access(0, 1'b1, 2'd0, 32'h21, 32'h000000AA, erd, eer);
        txn(1'b1, 2'd0, 32'h21, 32'h000000AA, rd, er, lat); release_resp();
        txn(1'b0, 2'd2, 32'h20, 32'h0, rd, er, lat); release_resp();
        tests_run++; if (rd !== 32'h1122AA44 || er !== 1'b0) begin tests_failed++; $display("FAIL byte_store_lane rdata=%h exp=1122aa44 err=%b", rd, er); end
        txn(1'b0, 2'd1, 32'h22, 32'h0, rd, er, lat); release_resp();
        tests_run++; if (rd !== 32'h00001122 || er !== 1'b0) begin tests_failed++; $display("FAIL half_load_hi rdata=%h exp=00001122 err=%b", rd, er); end
        txn(1'b0, 2'd0, 32'h23, 32'h0, rd, er, lat); release_resp();
        tests_run++; if (rd !== 32'h00000011 || er !== 1'b0) begin tests_failed++; $display("FAIL byte_load_3 rdata=%h exp=00000011 err=%b", rd, er); end
        model_access(0, 1'b1, 2'd1, 32'h22, 32'h0000BEEF, erd, eer);
        txn(1'b1, 2'd1, 32'h22, 32'h0000BEEF, rd, er, lat); release_resp();
        txn(1'b0, 2'd2, 32'h20, 32'h0, rd, er, lat); release_resp();
        tests_run++; if (rd !== 32'hBEEFAA44) begin tests_failed++; $display("FAIL half_store_hi rdata=%h exp=beefaa44", rd); end
    endtask

    task automatic test_errors;
        logic [31:0] rd, erd; logic er, eer; int lat;
        logic        ewe [4];
        logic [1:0]  esz [4];
        logic [31:0] ead [4];
        ewe[0] = 1'b0; esz[0] = 2'd2; ead[0] = 32'h22;
        ewe[1] = 1'b1; esz[1] = 2'd1; ead[1] = 32'h25;
        ewe[2] = 1'b1; esz[2] = 2'd2; ead[2] = 32'h1000;
        ewe[3] = 1'b1; esz[3] = 2'd3; ead[3] = 32'h20;
        sel = 0;
        for (int i = 0; i < 4; i++) begin
            model_access(0, ewe[i], esz[i], ead[i], 32'hFFFFFFFF, erd, eer);
            txn(ewe[i], esz[i], ead[i], 32'hFFFFFFFF, rd, er, lat); release_resp();
            tests_run++; if (er !== 1'b1 || rd !== 32'h0) begin tests_failed++; $display("FAIL err_case%0d err=%b rdata=%h exp 1/0", i, er, rd); end
        end
        for (int w = 8; w < 10; w++) begin
            model_access(0, 1'b0, 2'd2, 32'(4 * w), 32'h0, erd, eer);
            txn(1'b0, 2'd2, 32'(4 * w), 32'h0, rd, er, lat); release_resp();
            tests_run++; if (rd !== erd) begin tests_failed++; $display("FAIL err_no_side_effect w%0d rdata=%h exp=%h", w, rd, erd); end
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] rd, erd; logic er, eer; int lat;
        sel = 0;
        model_access(0, 1'b0, 2'd1, 32'h12, 32'h0, erd, eer);
        txn(1'b0, 2'd1, 32'h12, 32'h0, rd, er, lat);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            tests_run++;
            if (ob_valid !== 1'b1 || ob_rdata !== erd || ob_err !== 1'b0 || ob_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL backpressure c%0d valid=%b rdata=%h err=%b ready=%b exp 1/%h/0/0", c, ob_valid, ob_rdata, ob_err, ob_ready, erd);
            end
        end
        release_resp();
        tests_run++; if (ob_ready !== 1'b1 || ob_valid !== 1'b0) begin tests_failed++; $display("FAIL backpressure_release ready=%b valid=%b exp 1/0", ob_ready, ob_valid); end
    endtask

    task automatic test_reset_mid_store;
        logic [31:0] rd, erd; logic er, eer; int lat;
        sel = 2;
        model_access(2, 1'b0, 2'd2, 32'h40, 32'h0, erd, eer);
        @(negedge clk);
        tb_we = 1'b1; tb_size = 2'd2; tb_addr = 32'h40; tb_wdata = ~erd; tb_valid = 1'b1;
        @(posedge clk); #1 tb_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0; #1;
        tests_run++; if (ob_valid !== 1'b0 || ob_ready !== 1'b0) begin tests_failed++; $display("FAIL mid_reset valid=%b ready=%b exp 0/0", ob_valid, ob_ready); end
        @(negedge clk); rst_n = 1'b1;
        txn(1'b0, 2'd2, 32'h40, 32'h0, rd, er, lat); release_resp();
        tests_run++; if (rd !== erd || er !== 1'b0) begin tests_failed++; $display("FAIL mid_reset_store_dropped rdata=%h exp=%h", rd, erd); end
        tests_run++; if (lat != 4) begin tests_failed++; $display("FAIL wait4_latency got=%0d exp=4", lat); end
    endtask

    task automatic test_zero_wait;
        logic [31:0] rd, erd; logic er, eer; int lat;
        sel = 1;
        model_access(1, 1'b1, 2'd2, 32'h30, 32'hCAFEF00D, erd, eer);
        txn(1'b1, 2'd2, 32'h30, 32'hCAFEF00D, rd, er, lat); release_resp();
        tests_run++; if (lat != 0) begin tests_failed++; $display("FAIL zero_wait_store_latency got=%0d exp=0", lat); end
        txn(1'b0, 2'd2, 32'h30, 32'h0, rd, er, lat); release_resp();
        tests_run++; if (rd !== 32'hCAFEF00D || lat != 0) begin tests_failed++; $display("FAIL zero_wait_load rdata=%h lat=%0d exp cafef00d/0", rd, lat); end
    endtask

    task automatic test_random;
        logic [31:0] rd, erd, addr, wd; logic er, eer, we; logic [1:0] size; int lat;
        for (int i = 0; i < 200; i++) begin
            sel  = $urandom_range(0, 2);
            we   = 1'($urandom_range(0, 1));
            size = 2'($urandom_range(0, 3));
            addr = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 127));
            wd   = $urandom;
            model_access(sel, we, size, addr, wd, erd, eer);
            txn(we, size, addr, wd, rd, er, lat);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            release_resp();
            tests_run++;
            if (rd !== erd || er !== eer || lat != wait_of(sel)) begin
                tests_failed++;
                $display("FAIL random%0d dut%0d we=%b size=%0d addr=%h rdata=%h err=%b lat=%0d exp %h/%b/%0d", i, sel, we, size, addr, rd, er, lat, erd, eer, wait_of(sel));
            end
        end
    endtask

    initial begin
        tests_run = 0; tests_failed = 0;
        sel = 0; tb_valid = 1'b0; tb_we = 1'b0; tb_size = 2'd0; tb_addr = '0; tb_wdata = '0;
        tb_resp_ready = 1'b0; rst_n = 1'b0;
        test_reset();
        test_init();
        test_word();
        test_lanes();
        test_errors();
        test_backpressure();
        test_reset_mid_store();
        test_zero_wait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
